knn_local_sp_uram_pipe: RTL and testbench
=========================================

# knn_local_sp_uram_pipe

Parametrised single-clock URAM scratchpad for the partial-kNN kernel's local storage. It is the successor to the fixed 256x2048 single-port-per-cycle wrapper. It adds:
- separate simultaneous read and write ports;
- per-byte write enables;
- a configurable read-pipeline depth with a valid flag;
- a selectable read/write collision mode;
- an optional post-reset hardware clear sweep.

Kernel wrappers instantiate it once per local buffer.

## Interface
- DATA_WIDTH, 256: word width in bits; must be a multiple of 8.
- ADDR_RANGE, 2048: number of words; at most 2^ADDR_WIDTH.
- ADDR_WIDTH, 11: address width.
- READ_LATENCY, 2: cycles from read issue to data; legal 1..4.
- COLLISION_MODE, 0: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents undefined after reset.

Ports (`reset` is synchronous, active-low):
- clk  in  1  the single clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- rd_ce  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_q  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_q carries the result of a read.
- wr_ce  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers d[8i+7:8i].
- wr_d  in  DATA_WIDTH  write data.
- init_busy  out  1  clear sweep in progress; requests are ignored while high.

## Operation
FSM states: CLEAR, READY.
- **Reset** (reset=0 on an edge):
  - clear counter := 0; read pipeline flushed.
  - FSM := CLEAR if CLEAR_ON_RESET=1, else READY.
  - rd_q := 0, rd_valid := 0, init_busy := CLEAR_ON_RESET.
- **CLEAR**:
  - Writes all-zero to address = counter, one word per cycle, then counter += 1.
  - The write at address ADDR_RANGE-1 moves the FSM to READY.
  - rd_ce and wr_ce are ignored; nothing enters the read pipeline.
- **Reset mid-clear**: restarts the sweep at address 0.
- **READY write** (wr_ce=1): only bytes with wr_be[i]=1 update; the other bytes keep their value. wr_be=0 is a no-op.
- **READY read** (rd_ce=1): launches a read into a READ_LATENCY-deep valid/data pipeline. Back-to-back reads are accepted every cycle.
- **Out of range**:
  - A write with wr_addr >= ADDR_RANGE is dropped.
  - A read with rd_addr >= ADDR_RANGE returns all-zero with rd_valid=1.
- **Same-address read and write in the same cycle**:
  - COLLISION_MODE=0: returns the pre-write word.
  - COLLISION_MODE=1: returns the byte-merged post-write word (bypass path).
- A write in cycle t is always visible to a read issued at t+1 or later.
- **rd_q hold**: rd_q keeps its last value while rd_valid=0. It is not cleared by idle cycles.

## Timing
- Read issued at edge t gives rd_valid=1 with data at edge t+READ_LATENCY, for exactly one cycle per read.
- Writes commit at the edge where wr_ce=1 is sampled.
- Clear sweep:
  - Release reset at edge r; CLEAR writes occur at edges r+1 .. r+ADDR_RANGE.
  - init_busy falls after edge r+ADDR_RANGE.
  - The first accepted request is at edge r+ADDR_RANGE+1.
- Reads in flight when reset asserts are discarded; no rd_valid after reset.
- Throughput: one read plus one write per cycle, sustained, in READY.

## Test plan
- **Reset and clear**: defaults; hold reset=0 for 3 cycles, release.
  - init_busy=1 for exactly 2048 cycles, then 0.
  - Reads of addresses 0, 1047 and 2047 return 0 with rd_valid 2 cycles after issue.
  - A write issued during CLEAR has no effect.
- **Byte-enable write**:
  - Write 0xFF..FF to address 5, then write wr_d=0, wr_be=0x0000_0001.
  - Read of address 5 returns all-ones except byte 0 = 0x00.
- **Collision**: address 9 holds 0xAA (replicated); same-cycle write of 0x55 (full enables) and read of address 9.
  - COLLISION_MODE=0 returns 0xAA pattern.
  - COLLISION_MODE=1 returns 0x55 pattern.
  - A next-cycle read returns 0x55 in both modes.
- **Streaming reads**: READ_LATENCY=4; issue reads of addresses 0..15 on 16 consecutive cycles after preloading data = address.
  - rd_valid high for 16 consecutive cycles starting 4 cycles after the first issue, with data 0..15 in order.
  - rd_q holds 15 afterwards.
- **Reset mid-operation**: assert reset during the clear at counter=1000, and separately with 2 reads in flight.
  - The sweep restarts at 0: init_busy stays high for the full 2048 cycles after the new release.
  - No rd_valid appears for the flushed reads.
- **Out of range**: ADDR_RANGE=2000.
  - Write 0x1234 to address 2010: dropped.
  - Read of 2010 returns 0 with rd_valid=1.
  - Address 2010 mod 2000 = 10 is unchanged.

Source files
------------

// File: rtl/knn_local_sp_uram_pipe.sv
// knn_local_sp_uram_pipe: URAM scratchpad with independent read/write ports,
// byte-enabled writes, a configurable read pipeline with valid flag, a
// selectable same-address collision policy and an optional post-reset clear.
module knn_local_sp_uram_pipe #(
   parameter int DATA_WIDTH     = 256,
   parameter int ADDR_RANGE     = 2048,
   parameter int ADDR_WIDTH     = 11,
   parameter int READ_LATENCY   = 2,
   parameter int COLLISION_MODE = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_ce,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_q,
   output logic                    rd_valid,
   input  logic                    wr_ce,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [DATA_WIDTH-1:0]   wr_d,
   output logic                    init_busy
);

   localparam int                    NB    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   RANGE = (ADDR_WIDTH+1)'(ADDR_RANGE);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(ADDR_RANGE - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic                    init_busy_q;
   logic [DATA_WIDTH-1:0]   rd_q_q;
   logic                    rd_valid_q;
   logic [READ_LATENCY-1:0] vld_q;
   logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   mem   [ADDR_RANGE];

   logic                    rd_in_range, wr_in_range;
   logic                    rd_en, wr_en, clr_en;
   logic [DATA_WIDTH-1:0]   rd_word_d;

   assign rd_in_range = {1'b0, rd_addr} < RANGE;
   assign wr_in_range = {1'b0, wr_addr} < RANGE;
   // Requests only count once out of reset and after the sweep has finished.
   assign clr_en = reset && (state_q == CLEAR);
   assign rd_en  = reset && (state_q == READY) && rd_ce;
   assign wr_en  = reset && (state_q == READY) && wr_ce && wr_in_range;

   // Word entering the read pipeline: zero when out of range, optionally
   // byte-merged with a same-cycle write to the same address.
   always_comb begin
      rd_word_d = '0;
      if (rd_in_range) begin
         rd_word_d = mem[rd_addr];
         if (COLLISION_MODE == 1 && wr_en && wr_addr == rd_addr) begin
            for (int b = 0; b < NB; b++) begin
               if (wr_be[b]) rd_word_d[8*b +: 8] = wr_d[8*b +: 8];
            end
         end
      end
   end

   // Storage write port: clear sweep has priority, else byte-enabled write.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_d[8*b +: 8];
         end
      end
   end

   // Read data pipeline; qualified by vld_q so it needs no reset.
   always_ff @(posedge clk) begin
      dat_q[0] <= rd_word_d;
      for (int k = 1; k < READ_LATENCY; k++) dat_q[k] <= dat_q[k-1];
   end

   // Control: clear FSM, valid pipeline and held output register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         cnt_q       <= '0;
         init_busy_q <= (CLEAR_ON_RESET != 0);
         vld_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_q_q      <= '0;
      end else begin
         vld_q[0] <= rd_en;
         for (int k = 1; k < READ_LATENCY; k++) vld_q[k] <= vld_q[k-1];
         rd_valid_q <= vld_q[READ_LATENCY-1];
         // rd_q only moves on a completed read; idle cycles hold it.
         if (vld_q[READ_LATENCY-1]) rd_q_q <= dat_q[READ_LATENCY-1];
         case (state_q)
            CLEAR: begin
               if (cnt_q == LAST) begin
                  cnt_q       <= '0;
                  state_q     <= READY;
                  init_busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_q      = rd_q_q;
   assign rd_valid  = rd_valid_q;
   assign init_busy = init_busy_q;

endmodule

// File: tb/tb_knn_local_sp_uram_pipe.sv
// Directed bench for knn_local_sp_uram_pipe. Four instances share inputs:
// u0 defaults, u1 write-first collisions, u2 READ_LATENCY=4, u3 ADDR_RANGE=2000.
module tb_knn_local_sp_uram_pipe;
   localparam int DW = 256;
   localparam int NB = DW / 8;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rd_ce = 1'b0, wr_ce = 1'b0;
   logic [AW-1:0] rd_addr = '0, wr_addr = '0;
   logic [NB-1:0] wr_be = '0;
   logic [DW-1:0] wr_d = '0;
   logic [DW-1:0] q0, q1, q2, q3;
   logic          v0, v1, v2, v3, b0, b1, b2, b3;

   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   knn_local_sp_uram_pipe u0 (.clk(clk), .reset(reset), .rd_ce(rd_ce), .rd_addr(rd_addr),
      .rd_q(q0), .rd_valid(v0), .wr_ce(wr_ce), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_d(wr_d), .init_busy(b0));
   knn_local_sp_uram_pipe #(.COLLISION_MODE(1)) u1 (.clk(clk), .reset(reset), .rd_ce(rd_ce),
      .rd_addr(rd_addr), .rd_q(q1), .rd_valid(v1), .wr_ce(wr_ce), .wr_addr(wr_addr),
      .wr_be(wr_be), .wr_d(wr_d), .init_busy(b1));
   knn_local_sp_uram_pipe #(.READ_LATENCY(4)) u2 (.clk(clk), .reset(reset), .rd_ce(rd_ce),
      .rd_addr(rd_addr), .rd_q(q2), .rd_valid(v2), .wr_ce(wr_ce), .wr_addr(wr_addr),
      .wr_be(wr_be), .wr_d(wr_d), .init_busy(b2));
   knn_local_sp_uram_pipe #(.ADDR_RANGE(2000)) u3 (.clk(clk), .reset(reset), .rd_ce(rd_ce),
      .rd_addr(rd_addr), .rd_q(q3), .rd_valid(v3), .wr_ce(wr_ce), .wr_addr(wr_addr),
      .wr_be(wr_be), .wr_d(wr_d), .init_busy(b3));

   // one clock edge, then settle 1 time unit so outputs are stable to sample
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      wr_ce = 1'b1; wr_addr = a; wr_d = d; wr_be = be;
      tick();
      wr_ce = 1'b0;
   endtask

   task automatic rd_issue(input logic [AW-1:0] a);
      rd_ce = 1'b1; rd_addr = a;
      tick();
      rd_ce = 1'b0;
   endtask

   task automatic test_reset_clear();
      int n0, n3;
      logic [AW-1:0] addrs [4];
      addrs[0] = 11'd0; addrs[1] = 11'd1047; addrs[2] = 11'd2047; addrs[3] = 11'd100;
      reset = 1'b0;
      repeat (3) tick();
      n_chk++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b exp 0", v0); else n_pass++;
      n_chk++; if (q0 !== '0) $display("FAIL reset_rdq got %h exp 0", q0); else n_pass++;
      n_chk++; if (b0 !== 1'b1) $display("FAIL reset_busy got %b exp 1", b0); else n_pass++;
      reset = 1'b1;
      n0 = b0 ? 1 : 0;
      n3 = b3 ? 1 : 0;
      for (int i = 0; i < 2100; i++) begin
         if (i == 10) begin
            wr_ce = 1'b1; wr_addr = 11'd100; wr_d = '1; wr_be = '1;
         end
         tick();
         wr_ce = 1'b0;
         if (b0) n0++;
         if (b3) n3++;
      end
      n_chk++; if (n0 != 2048) $display("FAIL busy_len got %0d exp 2048", n0); else n_pass++;
      n_chk++; if (n3 != 2000) $display("FAIL busy_len_2000 got %0d exp 2000", n3); else n_pass++;
      n_chk++; if (b0 !== 1'b0) $display("FAIL busy_fall got %b exp 0", b0); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         rd_issue(addrs[j]);
         tick();
         n_chk++; if (v0 !== 1'b0) $display("FAIL clr_rd_early a=%0d got %b exp 0", addrs[j], v0); else n_pass++;
         tick();
         n_chk++;
         if (v0 !== 1'b1 || q0 !== '0)
            $display("FAIL clr_rd a=%0d got v=%b q=%h exp v=1 q=0", addrs[j], v0, q0);
         else n_pass++;
      end
   endtask

   task automatic test_byte_enable();
      logic [DW-1:0] exp;
      exp = {{31{8'hFF}}, 8'h00};
      wr(11'd5, '1, '1);
      wr(11'd5, '0, 32'h0000_0001);
      rd_issue(11'd5);
      tick(); tick();
      n_chk++;
      if (v0 !== 1'b1 || q0 !== exp) $display("FAIL byte_en got v=%b q=%h exp v=1 q=%h", v0, q0, exp);
      else n_pass++;
   endtask

   task automatic test_collision();
      logic [DW-1:0] pa, p5;
      pa = {32{8'hAA}};
      p5 = {32{8'h55}};
      wr(11'd9, pa, '1);
      wr_ce = 1'b1; wr_addr = 11'd9; wr_d = p5; wr_be = '1;
      rd_ce = 1'b1; rd_addr = 11'd9;
      tick();
      wr_ce = 1'b0; rd_ce = 1'b0;
      tick(); tick();
      n_chk++; if (v0 !== 1'b1 || q0 !== pa) $display("FAIL coll_rf got v=%b q=%h exp %h", v0, q0, pa); else n_pass++;
      n_chk++; if (v1 !== 1'b1 || q1 !== p5) $display("FAIL coll_wf got v=%b q=%h exp %h", v1, q1, p5); else n_pass++;
      rd_issue(11'd9);
      tick(); tick();
      n_chk++; if (q0 !== p5) $display("FAIL coll_next_rf got %h exp %h", q0, p5); else n_pass++;
      n_chk++; if (q1 !== p5) $display("FAIL coll_next_wf got %h exp %h", q1, p5); else n_pass++;
   endtask

   task automatic test_streaming();
      logic ev;
      for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i), '1);
      for (int k = 0; k < 24; k++) begin
         rd_ce = (k < 16); rd_addr = AW'(k);
         tick();
         ev = (k >= 4 && k < 20);
         n_chk++;
         if (v2 !== ev) $display("FAIL stream_v k=%0d got %b exp %b", k, v2, ev);
         else n_pass++;
         if (ev) begin
            n_chk++;
            if (q2 !== DW'(k - 4)) $display("FAIL stream_q k=%0d got %h exp %0d", k, q2, k - 4);
            else n_pass++;
         end
      end
      rd_ce = 1'b0;
      tick(); tick();
      n_chk++; if (q2 !== DW'(15)) $display("FAIL stream_hold got %h exp 15", q2); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int nv, n0;
      wr(11'd1500, '1, '1);
      rd_ce = 1'b1; rd_addr = 11'd3;
      tick();
      rd_addr = 11'd4;
      tick();
      rd_ce = 1'b0; reset = 1'b0;
      tick();
      reset = 1'b1;
      nv = (v0 | v1 | v2 | v3) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (v0 | v1 | v2 | v3) nv++;
      end
      n_chk++; if (nv != 0) $display("FAIL flush_valid got %0d valid cycles exp 0", nv); else n_pass++;
      repeat (990) tick();
      n_chk++; if (b0 !== 1'b1) $display("FAIL mid_busy got %b exp 1", b0); else n_pass++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n0 = b0 ? 1 : 0;
      for (int i = 0; i < 2100; i++) begin
         tick();
         if (b0) n0++;
      end
      n_chk++; if (n0 != 2048) $display("FAIL restart_len got %0d exp 2048", n0); else n_pass++;
      rd_issue(11'd1500);
      tick(); tick();
      n_chk++; if (v0 !== 1'b1 || q0 !== '0) $display("FAIL restart_clr got v=%b q=%h exp 0", v0, q0); else n_pass++;
   endtask

   task automatic test_out_of_range();
      wr(11'd10, DW'(16'hBEEF), '1);
      wr(11'd2010, DW'(16'h1234), '1);
      rd_issue(11'd10);
      tick(); tick();
      n_chk++; if (v3 !== 1'b1 || q3 !== DW'(16'hBEEF)) $display("FAIL oor_alias got v=%b q=%h exp beef", v3, q3); else n_pass++;
      rd_issue(11'd2010);
      tick(); tick();
      n_chk++; if (v3 !== 1'b1 || q3 !== '0) $display("FAIL oor_read got v=%b q=%h exp 0", v3, q3); else n_pass++;
      n_chk++; if (v0 !== 1'b1 || q0 !== DW'(16'h1234)) $display("FAIL inrange_2010 got v=%b q=%h exp 1234", v0, q0); else n_pass++;
   endtask

   initial begin
      test_reset_clear();
      test_byte_enable();
      test_collision();
      test_streaming();
      test_reset_mid();
      test_out_of_range();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
